// File: rtl/lsu_controller.sv
// Load/store unit controller: one outstanding data-memory access with timeout and lane steering.
// Optional misaligned-access trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_controller #(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rd_en,
   input  logic        wr_en,
   input  logic [2:0]  mem_acc_mode,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] load_data,
   output logic        load_valid,
   output logic        bus_err,
   output logic        misalign,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_mask,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   addr_q, addr_d;
   logic [1:0]    off_q, off_d;
   size_e         size_q, size_d;
   logic          uns_q, uns_d;
   logic          we_q, we_d;
   logic [3:0]    mask_q, mask_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   load_data_q, load_data_d;
   logic          load_valid_q, load_valid_d;
   logic          bus_err_q, bus_err_d;

   // Request decode from the live inputs (used only in IDLE)
   size_e       size_in;
   logic        uns_in, req_in, mis_in, trap;
   logic [1:0]  off_in;
   logic [3:0]  mask_in;
   logic [31:0] wdata_in;
   logic [31:0] shifted, ext;

   always_comb begin
      size_in  = SZ_WORD;
      uns_in   = 1'b0;
      off_in   = 2'b00;
      mask_in  = 4'b1111;
      wdata_in = wdata;
      case (mem_acc_mode)
         3'b000, 3'b011: size_in = SZ_BYTE;
         3'b001, 3'b100: size_in = SZ_HALF;
         default:        size_in = SZ_WORD;
      endcase
      uns_in = (mem_acc_mode == 3'b011) || (mem_acc_mode == 3'b100);
      req_in = rd_en | wr_en;
      mis_in = ((size_in == SZ_HALF) && addr[0]) || ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
      // Misaligned addresses are aligned down to the access size
      case (size_in)
         SZ_BYTE: begin
            off_in   = addr[1:0];
            mask_in  = 4'b0001 << addr[1:0];
            wdata_in = {4{wdata[7:0]}};
         end
         SZ_HALF: begin
            off_in   = {addr[1], 1'b0};
            mask_in  = addr[1] ? 4'b1100 : 4'b0011;
            wdata_in = {2{wdata[15:0]}};
         end
         default: begin
            off_in   = 2'b00;
            mask_in  = 4'b1111;
            wdata_in = wdata;
         end
      endcase
`ifdef LSU_MISALIGN_TRAP_EN
      trap = req_in & mis_in;
`else
      trap = 1'b0;
`endif
   end

   // Load extraction from the captured lane offset and mode
   always_comb begin
      shifted = bus_rdata >> {off_q, 3'b000};
      case (size_q)
         SZ_BYTE: ext = uns_q ? {24'h0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         SZ_HALF: ext = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      off_d        = off_q;
      size_d       = size_q;
      uns_d        = uns_q;
      we_d         = we_q;
      mask_d       = mask_q;
      wdata_d      = wdata_q;
      load_data_d  = load_data_q;
      load_valid_d = 1'b0;
      bus_err_d    = 1'b0;
      stall        = 1'b0;
      misalign     = 1'b0;
      case (state_q)
         IDLE: begin
            misalign = trap;
            if (req_in && !trap) begin
               stall   = 1'b1;
               state_d = WAIT;
               cnt_d   = '0;
               addr_d  = {addr[31:2], 2'b00};
               off_d   = off_in;
               size_d  = size_in;
               uns_d   = uns_in;
               we_d    = wr_en;
               mask_d  = mask_in;
               wdata_d = wdata_in;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (bus_ack) begin
               state_d = DONE;
               if (!we_q) begin
                  load_data_d  = ext;
                  load_valid_d = 1'b1;
               end
            end else if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
               state_d   = DONE;
               bus_err_d = 1'b1;
               if (!we_q) load_data_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         off_q        <= '0;
         size_q       <= SZ_WORD;
         uns_q        <= 1'b0;
         we_q         <= 1'b0;
         mask_q       <= '0;
         wdata_q      <= '0;
         load_data_q  <= '0;
         load_valid_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         off_q        <= off_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         we_q         <= we_d;
         mask_q       <= mask_d;
         wdata_q      <= wdata_d;
         load_data_q  <= load_data_d;
         load_valid_q <= load_valid_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus_req    = (state_q == WAIT);
   assign bus_we     = we_q;
   assign bus_addr   = addr_q;
   assign bus_wdata  = wdata_q;
   assign bus_mask   = mask_q;
   assign load_data  = load_data_q;
   assign load_valid = load_valid_q;
   assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_lsu_controller.sv
// Scoreboard bench for lsu_controller: stimulus pushes expected bus requests, loads,
// errors and stall lengths; a negedge monitor pops and compares.
module tb_lsu_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rd_en = 1'b0, wr_en = 1'b0;
   logic [2:0]  mem_acc_mode = 3'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        stall, load_valid, bus_err, misalign;
   logic [31:0] load_data;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_mask;
   logic        bus_ack = 1'b0;
   logic [31:0] bus_rdata = '0;

   lsu_controller #(.ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .wr_en(wr_en),
      .mem_acc_mode(mem_acc_mode), .addr(addr), .wdata(wdata),
      .stall(stall), .load_data(load_data), .load_valid(load_valid),
      .bus_err(bus_err), .misalign(misalign), .bus_req(bus_req),
      .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_mask(bus_mask), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [3:0]  m;
      logic        we;
      logic [31:0] wd;
   } req_t;

   req_t        req_q[$];
   logic [31:0] ld_q[$];
   int          err_q[$];
   int          stall_q[$];
   int          total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   task automatic exp_req(input logic [31:0] a, input logic [3:0] m, input logic we, input logic [31:0] wd);
      req_t r;
      r.a = a; r.m = m; r.we = we; r.wd = wd;
      req_q.push_back(r);
   endtask

   // Monitor: decoupled checker
   logic prev_req = 1'b0;
   int   srun = 0;
   always @(negedge clk) begin
      if (bus_req) begin
         if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
         else begin
            chk("bus_addr", bus_addr, req_q[0].a);
            chk("bus_mask", {28'h0, bus_mask}, {28'h0, req_q[0].m});
            chk("bus_we", {31'h0, bus_we}, {31'h0, req_q[0].we});
            chk("bus_wdata", bus_wdata, req_q[0].wd);
         end
      end
      if (prev_req && !bus_req && req_q.size() > 0) void'(req_q.pop_front());
      prev_req = bus_req;
      if (load_valid) begin
         if (ld_q.size() == 0) chk("unexpected_load_valid", 32'd1, 32'd0);
         else chk("load_data", load_data, ld_q.pop_front());
      end
      if (bus_err) begin
         if (err_q.size() == 0) chk("unexpected_bus_err", 32'd1, 32'd0);
         else begin
            void'(err_q.pop_front());
            chk("err_load_data", load_data, 32'h0);
            chk("err_load_valid", {31'h0, load_valid}, 32'h0);
         end
      end
      if (stall) srun++;
      else if (srun > 0) begin
         if (stall_q.size() == 0) chk("unexpected_stall", srun, 0);
         else chk("stall_cycles", srun, stall_q.pop_front());
         srun = 0;
      end
   end

   // One access; dly = WAIT cycles before ack (-1: never ack)
   task automatic access(input logic rd, input logic wr, input logic [2:0] mode,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] rdat, input int dly);
      int n;
      @(posedge clk); #1;
      rd_en = rd; wr_en = wr; mem_acc_mode = mode; addr = a; wdata = wd;
      @(posedge clk); #1;
      n = 0;
      while (stall && n < 300) begin
         bus_ack = (n == dly); bus_rdata = rdat;
         @(posedge clk); #1;
         bus_ack = 1'b0;
         n++;
      end
      if (n >= 300) chk("wait_bound", 32'd1, 32'd0);
      @(posedge clk); #1;
      rd_en = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      #2;
      chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_load_valid", {31'h0, load_valid}, 32'h0);
      chk("rst_bus_err", {31'h0, bus_err}, 32'h0);
      chk("rst_misalign", {31'h0, misalign}, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      chk("rst_bus_mask", {28'h0, bus_mask}, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Stray ack in IDLE must be ignored
      @(posedge clk); #1 bus_ack = 1'b1;
      @(posedge clk); #1 bus_ack = 1'b0;

      // Load word, ack in first WAIT
      exp_req(32'h100, 4'hF, 1'b0, 32'h0); ld_q.push_back(32'hDEADBEEF); stall_q.push_back(2);
      access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0);

      // Signed byte load, ack after 2 WAIT cycles
      exp_req(32'h100, 4'b1000, 1'b0, 32'h0); ld_q.push_back(32'hFFFFFF80); stall_q.push_back(4);
      access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80123456, 2);

      // Unsigned byte load
      exp_req(32'h100, 4'b1000, 1'b0, 32'h0); ld_q.push_back(32'h00000080); stall_q.push_back(2);
      access(1, 0, 3'b011, 32'h103, 32'h0, 32'h80123456, 0);

      // Half store; load_data must hold
      exp_req(32'h200, 4'b1100, 1'b1, 32'hABCDABCD); stall_q.push_back(2);
      access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 32'h0, 0);
      chk("load_data_hold", load_data, 32'h00000080);

      // Signed / unsigned half loads, upper half
      exp_req(32'h200, 4'b1100, 1'b0, 32'h0); ld_q.push_back(32'hFFFF8001); stall_q.push_back(3);
      access(1, 0, 3'b001, 32'h202, 32'h0, 32'h80011234, 1);
      exp_req(32'h200, 4'b1100, 1'b0, 32'h0); ld_q.push_back(32'h00008001); stall_q.push_back(2);
      access(1, 0, 3'b100, 32'h202, 32'h0, 32'h80011234, 0);

      // Byte store, lane 1
      exp_req(32'h100, 4'b0010, 1'b1, 32'hA5A5A5A5); stall_q.push_back(2);
      access(0, 1, 3'b000, 32'h101, 32'h123456A5, 32'h0, 0);

      // Timeout: 4 WAIT cycles then bus_err
      exp_req(32'h400, 4'hF, 1'b0, 32'h0); err_q.push_back(1); stall_q.push_back(5);
      access(1, 0, 3'b010, 32'h400, 32'h0, 32'h0, -1);

`ifdef LSU_MISALIGN_TRAP_EN
      // Misaligned word traps in IDLE
      @(posedge clk); #1;
      rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h101;
      #1;
      chk("misalign_pulse", {31'h0, misalign}, 32'h1);
      chk("misalign_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      chk("misalign_no_req", {31'h0, bus_req}, 32'h0);
      rd_en = 1'b0;
`else
      // Misaligned accesses aligned down
      exp_req(32'h100, 4'hF, 1'b0, 32'h0); ld_q.push_back(32'h11223344); stall_q.push_back(2);
      access(1, 0, 3'b010, 32'h101, 32'h0, 32'h11223344, 0);
      exp_req(32'h100, 4'b1100, 1'b0, 32'h0); ld_q.push_back(32'hFFFFBEEF); stall_q.push_back(2);
      access(1, 0, 3'b001, 32'h103, 32'h0, 32'hBEEF0000, 0);
`endif

      // Reset mid-WAIT abandons the access
      exp_req(32'h300, 4'hF, 1'b0, 32'h0); stall_q.push_back(2);
      @(posedge clk); #1;
      rd_en = 1'b1; mem_acc_mode = 3'b010; addr = 32'h300; wdata = 32'h0;
      @(posedge clk); #1;
      @(negedge clk); #1;
      rst_n = 1'b0; rd_en = 1'b0;
      #1;
      chk("rst_mid_bus_req", {31'h0, bus_req}, 32'h0);
      chk("rst_mid_stall", {31'h0, stall}, 32'h0);
      chk("rst_mid_load_data", load_data, 32'h0);
      @(posedge clk); #1 rst_n = 1'b1;

      // rd_en and wr_en together act as a store
      exp_req(32'h500, 4'hF, 1'b1, 32'hCAFEF00D); stall_q.push_back(2);
      access(1, 1, 3'b010, 32'h500, 32'hCAFEF00D, 32'h0, 0);

      repeat (3) @(posedge clk);
      #1;
      chk("req_q_empty", req_q.size(), 0);
      chk("ld_q_empty", ld_q.size(), 0);
      chk("err_q_empty", err_q.size(), 0);
      chk("stall_q_empty", stall_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 The block SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum number of WAIT cycles before a bus error.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-004 The block SHALL have port rd_en, input, 1, the load request from the control unit.
REQ-005 The block SHALL have port wr_en, input, 1, the store request from the control unit.
REQ-006 The block SHALL have port mem_acc_mode, input, 3, with encoding 000 byte, 001 half, 010 word, 011 byte unsigned, 100 half unsigned; other codes are treated as word.
REQ-007 The block SHALL have port addr, input, 32, the effective address (ALU result).
REQ-008 The block SHALL have port wdata, input, 32, the store data (rs2).
REQ-009 The block SHALL have port stall, output, 1, which freezes the pipeline while an access is in progress.
REQ-010 The block SHALL have port load_data, output, 32, the extended load result.
REQ-011 The block SHALL have port load_valid, output, 1, a one-cycle pulse marking load_data valid.
REQ-012 The block SHALL have port bus_err, output, 1, a one-cycle pulse on timeout.
REQ-013 The block SHALL have port misalign, output, 1, a one-cycle misaligned-access flag (see Configuration).
REQ-014 The block SHALL have ports bus_req, bus_we, bus_addr[31:0], bus_wdata[31:0] and bus_mask[3:0], all outputs, forming the data-memory request.
REQ-015 The block SHALL have ports bus_ack, input, 1, and bus_rdata, input, 32, forming the memory response; bus_rdata is valid with bus_ack.

Function
REQ-016 The block SHALL use FSM states IDLE, WAIT and DONE.
REQ-017 In IDLE, when rd_en or wr_en is high and the access is accepted, stall SHALL be asserted combinationally in the same cycle and the FSM SHALL go to WAIT.
REQ-018 On the IDLE-to-WAIT edge, the address, mode, write data and write flag SHALL be captured into registers.
REQ-019 When rd_en and wr_en are both high, the access SHALL be treated as a store.
REQ-020 In WAIT, bus_req SHALL be high, stall SHALL be high, and bus_addr, bus_we, bus_wdata and bus_mask SHALL be driven from the captured registers and held stable.
REQ-021 bus_addr SHALL equal the captured address with bits [1:0] forced to 0.
REQ-022 bus_mask SHALL be 1<<addr[1:0] for byte accesses, 0011 for a half access with addr[1]=0, 1100 for a half access with addr[1]=1, and 1111 for word accesses; store modes 011/100 SHALL use the byte/half masks.
REQ-023 bus_wdata SHALL be the byte replicated in all 4 lanes for byte stores, the halfword replicated in both halves for half stores, and wdata unchanged for word stores.
REQ-024 In WAIT, when bus_ack is high, a load SHALL register (bus_rdata >> 8*addr[1:0]) sign- or zero-extended per mode into load_data, and the FSM SHALL go to DONE.
REQ-025 In DONE, stall SHALL be low, load_valid SHALL be high for loads only, rd_en and wr_en SHALL be ignored (same instruction still presented), and the next state SHALL be IDLE.
REQ-026 Minimum access latency SHALL be 3 cycles: IDLE, WAIT with ack, then DONE.
REQ-027 In WAIT, a cycle counter SHALL start at 0 and increment once per cycle without ack.
REQ-028 When the counter reaches ACK_TIMEOUT without ack, the FSM SHALL go to DONE with bus_err pulsed, load_data 0 and load_valid 0.
REQ-029 bus_ack in IDLE or DONE SHALL be ignored.
REQ-030 load_data SHALL hold its value until the next load completes.
REQ-031 Outside WAIT, bus_req SHALL be 0.

Reset
REQ-032 When rst_n is low, the FSM SHALL immediately go to IDLE regardless of clk, and the counter, bus_req, bus_we, bus_mask, bus_addr, bus_wdata, load_data, load_valid, bus_err and misalign SHALL be set to 0.
REQ-033 A reset asserted mid-WAIT SHALL drop bus_req asynchronously and abandon the access.

Configuration
REQ-034 With LSU_MISALIGN_TRAP_EN defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL pulse misalign in that IDLE cycle, issue no bus request, keep stall low and leave the FSM in IDLE.
REQ-035 Without LSU_MISALIGN_TRAP_EN, misalign SHALL be tied 0, and misaligned addresses SHALL be aligned down to the access size before the mask and extraction are computed.

Verification
REQ-036 Load word: rd_en=1, mode=010, addr=0x100, ack in the first WAIT cycle with rdata=0xDEADBEEF -> bus_mask=1111, DONE gives load_data=0xDEADBEEF with load_valid=1, stall high for exactly 2 cycles.
REQ-037 Signed byte load: mode=000, addr=0x103, rdata=0x80123456 -> bus_mask=1000, load_data=0xFFFFFF80; with mode=011 -> load_data=0x00000080.
REQ-038 Half store: wr_en=1, mode=001, addr=0x202, wdata=0x0000ABCD -> bus_we=1, bus_mask=1100, bus_wdata=0xABCDABCD, load_valid stays 0.
REQ-039 Timeout: ACK_TIMEOUT=4, no ack -> bus_err pulses 1 cycle after 4 WAIT cycles, load_data=0, then IDLE.
REQ-040 Misaligned word, addr=0x101: with LSU_MISALIGN_TRAP_EN -> misalign=1, bus_req never asserted; without it -> bus_addr=0x100, bus_mask=1111.
REQ-041 Reset in WAIT, then both rd_en and wr_en high -> bus_req falls with rst_n; after release the access is a store (bus_we=1).
